// File: rtl/sva_result_collector.sv
// Collects checker succ/fail/lazy_succ pulses into saturating counts, a verdict and an optional event FIFO.
// Latency: counters/verdict 1 cycle; FIFO head visible 1 cycle after push. Backpressure: evt_ready pops, full FIFO drops pushes.
// Optional event FIFO built only when SVA_EVT_FIFO_EN is defined; otherwise evt_* outputs are tied 0.

`ifdef SVA_EVT_FIFO_EN
module sva_evt_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         push_ok,
  output logic [W-1:0] head_dat,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         full, pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign push_ok = push && (!full || pop_ok);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule
`endif

module sva_result_collector #(
  parameter int CNT_WIDTH  = 16,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 clr,
  input  logic                 tick,
  input  logic                 succ,
  input  logic                 fail,
  input  logic                 lazy_succ,
  output logic [CNT_WIDTH-1:0] succ_cnt,
  output logic [CNT_WIDTH-1:0] fail_cnt,
  output logic [CNT_WIDTH-1:0] lazy_cnt,
  output logic [TS_WIDTH-1:0]  period_cnt,
  output logic [1:0]           verdict,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [1:0]           evt_type,
  output logic [TS_WIDTH-1:0]  evt_period,
  output logic                 evt_overflow,
  output logic                 evt_merged
);
  typedef enum logic [1:0] {
    V_NONE    = 2'd0,
    V_PASSING = 2'd1,
    V_FAILED  = 2'd2
  } verdict_t;

  verdict_t state_q, state_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      succ_cnt   <= '0;
      fail_cnt   <= '0;
      lazy_cnt   <= '0;
      period_cnt <= '0;
    end else if (clr) begin
      succ_cnt   <= '0;
      fail_cnt   <= '0;
      lazy_cnt   <= '0;
      period_cnt <= '0;
    end else begin
      if (succ && !(&succ_cnt))      succ_cnt <= succ_cnt + CNT_WIDTH'(1);
      if (fail && !(&fail_cnt))      fail_cnt <= fail_cnt + CNT_WIDTH'(1);
      if (lazy_succ && !(&lazy_cnt)) lazy_cnt <= lazy_cnt + CNT_WIDTH'(1);
      if (tick)                      period_cnt <= period_cnt + TS_WIDTH'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= V_NONE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr)                                              state_d = V_NONE;
    else if (fail)                                        state_d = V_FAILED;
    else if (state_q == V_NONE && (succ || lazy_succ))    state_d = V_PASSING;
  end

  assign verdict = state_q;

`ifdef SVA_EVT_FIFO_EN
  logic                push, push_ok, fifo_empty;
  logic [1:0]          push_type;
  logic [TS_WIDTH+1:0] head_dat;

  assign push = (succ || fail || lazy_succ) && !clr;

  always_comb begin
    push_type = 2'd3;
    if (fail)      push_type = 2'd2;
    else if (succ) push_type = 2'd1;
  end

  sva_evt_fifo #(.W(TS_WIDTH + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .flush    (clr),
    .push     (push),
    .push_dat ({push_type, period_cnt}),
    .pop      (evt_valid && evt_ready),
    .push_ok  (push_ok),
    .head_dat (head_dat),
    .empty    (fifo_empty)
  );

  assign evt_valid  = !fifo_empty;
  assign evt_type   = evt_valid ? head_dat[TS_WIDTH+1:TS_WIDTH] : 2'd0;
  assign evt_period = evt_valid ? head_dat[TS_WIDTH-1:0] : '0;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      evt_overflow <= 1'b0;
      evt_merged   <= 1'b0;
    end else if (clr) begin
      evt_overflow <= 1'b0;
      evt_merged   <= 1'b0;
    end else begin
      if (push && !push_ok) evt_overflow <= 1'b1;
      if ((fail && (succ || lazy_succ)) || (succ && lazy_succ)) evt_merged <= 1'b1;
    end
  end
`else
  logic unused_evt_ready;
  assign unused_evt_ready = evt_ready;
  assign evt_valid    = 1'b0;
  assign evt_type     = 2'd0;
  assign evt_period   = '0;
  assign evt_overflow = 1'b0;
  assign evt_merged   = 1'b0;
`endif
endmodule

// File: tb/tb_sva_result_collector.sv
// Directed bench for sva_result_collector: vector table plus multi-cycle FIFO, saturation and reset sequences.
module tb_sva_result_collector;
  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic sys_rst_n, clr, tick, succ, fail, lazy_succ, evt_ready;
  logic [15:0] succ_cnt, fail_cnt, lazy_cnt, period_cnt, evt_period;
  logic [1:0]  verdict, evt_type;
  logic        evt_valid, evt_overflow, evt_merged;

  logic [3:0]  s4, f4, l4;
  logic [15:0] p4, ep4;
  logic [1:0]  v4, et4;
  logic        evv4, eov4, emg4;

`ifdef SVA_EVT_FIFO_EN
  localparam int FIFO_EN = 1;
`else
  localparam int FIFO_EN = 0;
`endif

  sva_result_collector dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clr(clr), .tick(tick),
    .succ(succ), .fail(fail), .lazy_succ(lazy_succ),
    .succ_cnt(succ_cnt), .fail_cnt(fail_cnt), .lazy_cnt(lazy_cnt),
    .period_cnt(period_cnt), .verdict(verdict),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
    .evt_period(evt_period), .evt_overflow(evt_overflow), .evt_merged(evt_merged)
  );

  sva_result_collector #(.CNT_WIDTH(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clr(clr), .tick(tick),
    .succ(succ), .fail(fail), .lazy_succ(lazy_succ),
    .succ_cnt(s4), .fail_cnt(f4), .lazy_cnt(l4),
    .period_cnt(p4), .verdict(v4),
    .evt_valid(evv4), .evt_ready(evt_ready), .evt_type(et4),
    .evt_period(ep4), .evt_overflow(eov4), .evt_merged(emg4)
  );

  typedef struct {
    int s, f, l, t, c;
    int es, ef, el, ep, ev;
    int evv, evt, evp, emg;
  } vec_t;

  vec_t tbl [19];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle();
    succ = 0; fail = 0; lazy_succ = 0; tick = 0; clr = 0;
  endtask

  function automatic int fe(input int v);
    return (FIFO_EN != 0) ? v : 0;
  endfunction

  int n;

  initial begin
    //          s f l t c   es ef el ep ev  evv evt evp emg
    tbl[0]  = '{1,0,0,0,0,  1, 0, 0, 0, 1,  1,  1,  0,  0};
    tbl[1]  = '{1,0,0,1,0,  2, 0, 0, 1, 1,  1,  1,  0,  0};
    tbl[2]  = '{0,0,0,0,0,  2, 0, 0, 1, 1,  0,  0,  0,  0};
    tbl[3]  = '{1,0,0,0,0,  3, 0, 0, 1, 1,  1,  1,  1,  0};
    tbl[4]  = '{0,0,1,0,0,  3, 0, 1, 1, 1,  1,  3,  1,  0};
    tbl[5]  = '{0,0,0,1,0,  3, 0, 1, 2, 1,  0,  0,  0,  0};
    tbl[6]  = '{0,0,0,1,0,  3, 0, 1, 3, 1,  0,  0,  0,  0};
    tbl[7]  = '{0,0,0,1,0,  3, 0, 1, 4, 1,  0,  0,  0,  0};
    tbl[8]  = '{0,0,0,1,0,  3, 0, 1, 5, 1,  0,  0,  0,  0};
    tbl[9]  = '{1,1,0,0,0,  4, 1, 1, 5, 2,  1,  2,  5,  1};
    tbl[10] = '{0,0,0,0,1,  0, 0, 0, 0, 0,  0,  0,  0,  0};
    tbl[11] = '{0,0,1,0,0,  0, 0, 1, 0, 1,  1,  3,  0,  0};
    tbl[12] = '{0,1,0,0,0,  0, 1, 1, 0, 2,  1,  2,  0,  0};
    tbl[13] = '{1,0,0,0,0,  1, 1, 1, 0, 2,  1,  1,  0,  0};
    tbl[14] = '{1,0,0,0,0,  2, 1, 1, 0, 2,  1,  1,  0,  0};
    tbl[15] = '{0,0,0,0,0,  2, 1, 1, 0, 2,  0,  0,  0,  0};
    tbl[16] = '{1,1,1,1,1,  0, 0, 0, 0, 0,  0,  0,  0,  0};
    tbl[17] = '{1,0,1,0,0,  1, 0, 1, 0, 1,  1,  1,  0,  1};
    tbl[18] = '{0,0,0,0,1,  0, 0, 0, 0, 0,  0,  0,  0,  0};

    sys_rst_n = 0; evt_ready = 1; idle();
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_succ", succ_cnt, 0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_period", period_cnt, 0);
    chk("rst_verdict", verdict, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_type", evt_type, 0);
    chk("rst_s4", s4, 0);
    sys_rst_n = 1;

    for (int i = 0; i < 19; i++) begin
      succ = (tbl[i].s != 0); fail = (tbl[i].f != 0); lazy_succ = (tbl[i].l != 0);
      tick = (tbl[i].t != 0); clr = (tbl[i].c != 0);
      step();
      idle();
      chk($sformatf("v%0d_succ", i), succ_cnt, tbl[i].es);
      chk($sformatf("v%0d_fail", i), fail_cnt, tbl[i].ef);
      chk($sformatf("v%0d_lazy", i), lazy_cnt, tbl[i].el);
      chk($sformatf("v%0d_period", i), period_cnt, tbl[i].ep);
      chk($sformatf("v%0d_verdict", i), verdict, tbl[i].ev);
      chk($sformatf("v%0d_evt_valid", i), evt_valid, fe(tbl[i].evv));
      chk($sformatf("v%0d_evt_type", i), evt_type, fe(tbl[i].evt));
      chk($sformatf("v%0d_evt_period", i), evt_period, fe(tbl[i].evp));
      chk($sformatf("v%0d_merged", i), evt_merged, fe(tbl[i].emg));
    end

    // Overflow: 9 pushes into an 8-deep FIFO with no reader
    evt_ready = 0;
    repeat (9) begin fail = 1; step(); idle(); end
    chk("ovf_fail_cnt", fail_cnt, 9);
    chk("ovf_flag", evt_overflow, fe(1));
    chk("ovf_valid", evt_valid, fe(1));
    chk("ovf_type", evt_type, fe(2));
    evt_ready = 1; n = 0;
    for (int i = 0; i < 20; i++) begin
      if (evt_valid) n++;
      step();
    end
    chk("ovf_drain_count", n, fe(8));

    // Full FIFO: simultaneous push and pop both succeed without overflow
    clr = 1; step(); idle();
    evt_ready = 0;
    repeat (8) begin fail = 1; step(); idle(); end
    chk("full_no_ovf", evt_overflow, 0);
    fail = 1; evt_ready = 1; step(); idle(); evt_ready = 0;
    chk("full_pushpop_ovf", evt_overflow, 0);
    chk("full_pushpop_cnt", fail_cnt, 9);
    fail = 1; step(); idle();
    chk("full_push_ovf", evt_overflow, fe(1));
    evt_ready = 1; n = 0;
    for (int i = 0; i < 20; i++) begin
      if (evt_valid) n++;
      step();
    end
    chk("full_drain_count", n, fe(8));

    // One-entry FIFO: push and pop in the same cycle keeps occupancy at 1
    clr = 1; step(); idle();
    evt_ready = 0;
    succ = 1; step(); idle();
    chk("one_valid", evt_valid, fe(1));
    chk("one_type", evt_type, fe(1));
    tick = 1; step(); idle();
    chk("one_hold_period", evt_period, 0);
    lazy_succ = 1; evt_ready = 1; step(); idle(); evt_ready = 0;
    chk("one_swap_valid", evt_valid, fe(1));
    chk("one_swap_type", evt_type, fe(3));
    chk("one_swap_period", evt_period, fe(1));
    step();
    chk("one_still_valid", evt_valid, fe(1));
    evt_ready = 1; step();
    chk("one_empty_valid", evt_valid, 0);
    chk("one_empty_type", evt_type, 0);

    // Saturation on the 4-bit instance, then clr beats a same-cycle fail
    clr = 1; step(); idle();
    repeat (20) begin succ = 1; step(); idle(); end
    chk("sat_s4", s4, 15);
    chk("sat_s16", succ_cnt, 20);
    clr = 1; fail = 1; step(); idle();
    chk("clr_s4", s4, 0);
    chk("clr_f4", f4, 0);
    chk("clr_v4", v4, 0);
    chk("clr_fail", fail_cnt, 0);
    chk("clr_verdict", verdict, 0);

    // Asynchronous reset with three entries queued
    evt_ready = 0;
    repeat (3) begin succ = 1; tick = 1; step(); idle(); end
    chk("pre_rst_valid", evt_valid, fe(1));
    chk("pre_rst_succ", succ_cnt, 3);
    chk("pre_rst_period", period_cnt, 3);
    #2 sys_rst_n = 0;
    #1;
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_succ", succ_cnt, 0);
    chk("mid_rst_period", period_cnt, 0);
    chk("mid_rst_verdict", verdict, 0);
    step();
    sys_rst_n = 1;
    succ = 1; step(); idle();
    chk("post_rst_succ", succ_cnt, 1);
    chk("post_rst_verdict", verdict, 1);
    chk("post_rst_valid", evt_valid, fe(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
